// File: rtl/cache_pkg.sv
// ============================================================================
// Module : cache_pkg
// Brief  : Shared cache types and constants (icache_assoc, future dcache).
// Rev    : 1.0  initial set-associative icache support
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int BYTE_OFF   = 2;
    localparam int LINE_WORDS = 2;
    localparam int LINE_SETS  = 8;
    localparam int LINE_TAGW  = 32 - BYTE_OFF - $clog2(LINE_WORDS) - $clog2(LINE_SETS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } istate_assoc_t;

    // Line layout at the default geometry; users with other geometries mirror it locally.
    typedef struct packed {
        logic                         valid;
        logic [LINE_TAGW-1:0]         tag;
        logic [LINE_WORDS-1:0][31:0]  data;
    } icache_line_t;

endpackage

`default_nettype wire

// File: rtl/icache_tagmatch.sv
// ============================================================================
// Module : icache_tagmatch
// Brief  : Combinational tag compare across the ways of one set; one-hot hit.
// Rev    : 1.0  initial
// ============================================================================
`default_nettype none

module icache_tagmatch #(
    parameter int WAYS = 2,
    parameter int TAGW = 26
) (
    input  logic [WAYS-1:0][TAGW-1:0] i_tags,
    input  logic [WAYS-1:0]           i_valids,
    input  logic [TAGW-1:0]           i_tag,
    output logic                      o_hit,
    output logic [WAYS-1:0]           o_hit_way
);

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign o_hit_way[g] = i_valids[g] && (i_tags[g] == i_tag);
    end

    assign o_hit = |o_hit_way;

endmodule

`default_nettype wire

// File: rtl/icache_assoc.sv
// ============================================================================
// Module : icache_assoc
// Brief  : Set-associative, multi-word-block instruction cache with flush.
//          Optional hit/miss counters when ICACHE_PERF_EN is defined.
// Rev    : 1.0  initial
// ============================================================================
`default_nettype none

module icache_assoc
    import cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 8,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int WOFF  = $clog2(WORDS);
    localparam int IDXW  = $clog2(SETS);
    localparam int TAGW  = 32 - BYTE_OFF - WOFF - IDXW;
    localparam int WOFFW = (WOFF > 0) ? WOFF : 1;
    localparam int WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef struct packed {
        logic                   valid;
        logic [TAGW-1:0]        tag;
        logic [WORDS-1:0][31:0] data;
    } line_t;

    line_t           r_line [WAYS][SETS];
    logic [WAYW-1:0] r_ptr  [SETS];
    istate_assoc_t   r_state;
    logic [TAGW-1:0] r_tag;
    logic [IDXW-1:0] r_idx;
    logic [WOFFW-1:0] r_cnt;
    logic [31:0]     r_buf  [WORDS];

    logic [TAGW-1:0]            w_tag;
    logic [IDXW-1:0]            w_idx;
    logic [WOFFW-1:0]           w_word;
    logic [WAYS-1:0][TAGW-1:0]  w_tags;
    logic [WAYS-1:0]            w_vals;
    logic                       w_hit;
    logic [WAYS-1:0]            w_hit_way;
    logic [31:0]                w_rdata;
    logic                       w_ihit;
    logic [WAYW-1:0]            w_victim;
    logic                       w_from_ptr;
    logic                       w_last;
    logic [WORDS-1:0][31:0]     w_fill_data;
    logic [31:0]                w_fill_addr;
    logic                       w_unused_addr;

    assign w_tag         = imemaddr[31 -: TAGW];
    assign w_idx         = imemaddr[BYTE_OFF+WOFF +: IDXW];
    assign w_unused_addr = &{1'b0, imemaddr[1:0]};

    if (WOFF > 0) begin : g_multiword
        assign w_word      = imemaddr[BYTE_OFF +: WOFF];
        assign w_fill_addr = {r_tag, r_idx, r_cnt, 2'b00};
    end else begin : g_singleword
        assign w_word      = 1'b0;
        assign w_fill_addr = {r_tag, r_idx, 2'b00};
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_tags[w] = r_line[w][w_idx].tag;
            w_vals[w] = r_line[w][w_idx].valid;
        end
    end

    icache_tagmatch #(
        .WAYS (WAYS),
        .TAGW (TAGW)
    ) u_tagmatch (
        .i_tags    (w_tags),
        .i_valids  (w_vals),
        .i_tag     (w_tag),
        .o_hit     (w_hit),
        .o_hit_way (w_hit_way)
    );

    always_comb begin
        w_rdata = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit_way[w]) begin
                w_rdata = w_rdata | r_line[w][w_idx].data[w_word];
            end
        end
    end

    // Lowest invalid way wins; the rotating pointer is only consulted for a full set.
    always_comb begin
        w_victim   = r_ptr[r_idx];
        w_from_ptr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_line[w][r_idx].valid) begin
                w_victim   = WAYW'(w);
                w_from_ptr = 1'b0;
            end
        end
    end

    always_comb begin
        for (int w = 0; w < WORDS; w++) begin
            w_fill_data[w] = (WOFFW'(w) == r_cnt) ? iload : r_buf[w];
        end
    end

    assign w_last   = (r_cnt == WOFFW'(WORDS - 1));
    assign w_ihit   = (r_state == IDLE) && imemREN && !flush && w_hit;
    assign ihit     = w_ihit;
    assign imemload = w_ihit ? w_rdata : 32'd0;
    assign iREN     = (r_state == FILL);
    assign iaddr    = (r_state == FILL) ? w_fill_addr : 32'd0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_line[w][s].valid <= 1'b0;
                end
            end
            for (int s = 0; s < SETS; s++) begin
                r_ptr[s] <= '0;
            end
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_line[w][s].valid <= 1'b0;
                end
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (imemREN && !w_hit) begin
                        r_tag   <= w_tag;
                        r_idx   <= w_idx;
                        r_cnt   <= '0;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        r_buf[r_cnt] <= iload;
                        if (w_last) begin
                            r_line[w_victim][r_idx] <= '{valid: 1'b1, tag: r_tag, data: w_fill_data};
                            if (w_from_ptr) begin
                                r_ptr[r_idx] <= (r_ptr[r_idx] == WAYW'(WAYS - 1)) ? '0
                                                : r_ptr[r_idx] + 1'b1;
                            end
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_ihit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if ((r_state == IDLE) && imemREN && !flush && !w_hit) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_assoc.sv
// ============================================================================
// Module : tb_icache_assoc
// Brief  : Directed, table-driven bench for icache_assoc (WAYS=2,SETS=8,WORDS=2).
// Rev    : 1.0  initial
// ============================================================================
`default_nettype none

module tb_icache_assoc;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    icache_assoc #(.WAYS(2), .SETS(8), .WORDS(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .flush    (flush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h40)      return 32'h11111111;
        else if (a == 32'h44) return 32'h22222222;
        else                  return {a[15:0], ~a[15:0]};
    endfunction

    always_comb iload = memf(iaddr);

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic [31:0] data;
    } vec_t;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Combinational lookup only; no clock edge is taken with imemREN high.
    task automatic apply(input vec_t v);
        imemREN  = 1'b1;
        imemaddr = v.addr;
        #1;
        chk($sformatf("lookup_hit@%h", v.addr), {31'd0, ihit}, {31'd0, v.hit});
        if (v.hit) chk($sformatf("lookup_data@%h", v.addr), imemload, v.data);
        chk($sformatf("lookup_iren@%h", v.addr), {31'd0, iREN}, 32'd0);
        imemREN = 1'b0;
        #1;
    endtask

    // Miss on a, fill both words with wc wait cycles per word, then hit.
    task automatic do_fill(input logic [31:0] a, input int wc);
        logic [31:0] base;
        base     = {a[31:3], 3'b000};
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b0;
        #1;
        chk("fill_miss", {31'd0, ihit}, 32'd0);
        tick();
        exp_miss++;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < wc; k++) begin
                iwait = 1'b1;
                #1;
                chk("fill_wait_iren", {31'd0, iREN}, 32'd1);
                chk("fill_wait_iaddr", iaddr, base + 32'(4 * w));
                chk("fill_wait_ihit", {31'd0, ihit}, 32'd0);
                tick();
            end
            iwait = 1'b0;
            #1;
            chk("fill_iaddr", iaddr, base + 32'(4 * w));
            tick();
        end
        #1;
        chk("fill_done_hit", {31'd0, ihit}, 32'd1);
        chk("fill_done_data", imemload, memf({a[31:2], 2'b00}));
        imemREN = 1'b0;
    endtask

    vec_t conf1 [7];
    vec_t conf2 [3];
    vec_t warm  [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        conf1[0] = '{32'h140, 1'b1, memf(32'h140)};
        conf1[1] = '{32'h144, 1'b1, memf(32'h144)};
        conf1[2] = '{32'h240, 1'b1, memf(32'h240)};
        conf1[3] = '{32'h244, 1'b1, memf(32'h244)};
        conf1[4] = '{32'h040, 1'b0, 32'h0};
        conf1[5] = '{32'h044, 1'b0, 32'h0};
        conf1[6] = '{32'h048, 1'b0, 32'h0};
        conf2[0] = '{32'h040, 1'b1, 32'h11111111};
        conf2[1] = '{32'h240, 1'b1, memf(32'h240)};
        conf2[2] = '{32'h140, 1'b0, 32'h0};
        warm[0]  = '{32'h000, 1'b1, memf(32'h000)};
        warm[1]  = '{32'h00C, 1'b1, memf(32'h00C)};
        warm[2]  = '{32'h010, 1'b1, memf(32'h010)};
        warm[3]  = '{32'h01C, 1'b1, memf(32'h01C)};

        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b0;
        tick();
        tick();
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iren", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        RST = 1'b0;

        // Basic fill of 0x40 with the exact handshake trace.
        imemREN = 1'b1; imemaddr = 32'h40;
        #1;
        chk("b_miss_ihit", {31'd0, ihit}, 32'd0);
        tick();
        exp_miss++;
        chk("b_fill0_iren", {31'd0, iREN}, 32'd1);
        chk("b_fill0_iaddr", iaddr, 32'h40);
        chk("b_fill0_ihit", {31'd0, ihit}, 32'd0);
        tick();
        chk("b_fill1_iaddr", iaddr, 32'h44);
        tick();
        chk("b_hit", {31'd0, ihit}, 32'd1);
        chk("b_hit_data", imemload, 32'h11111111);
        chk("b_hit_iren", {31'd0, iREN}, 32'd0);
        imemaddr = 32'h44;
        #1;
        chk("b_hit44", {31'd0, ihit}, 32'd1);
        chk("b_hit44_data", imemload, 32'h22222222);
        chk("b_hit44_iren", {31'd0, iREN}, 32'd0);
        imemREN = 1'b0;
        tick();

        // Conflict in set 0: third block evicts way 0.
        do_fill(32'h140, 0);
        tick();
        do_fill(32'h240, 0);
        tick();
        foreach (conf1[i]) apply(conf1[i]);

        // Slow memory refill of 0x40 replaces 0x140 (pointer moved to way 1).
        do_fill(32'h40, 3);
        tick();
        foreach (conf2[i]) apply(conf2[i]);

        // Flush after word 0 of a fill.
        imemREN = 1'b1; imemaddr = 32'h80;
        tick();
        exp_miss++;
        tick();
        flush = 1'b1; iwait = 1'b1; imemREN = 1'b0;
        #1;
        chk("fl_iren_before", {31'd0, iREN}, 32'd1);
        chk("fl_iaddr_before", iaddr, 32'h84);
        tick();
        flush = 1'b0; iwait = 1'b0;
        chk("fl_iren_after", {31'd0, iREN}, 32'd0);
        chk("fl_ihit_after", {31'd0, ihit}, 32'd0);
        tick();
        chk("fl_idle_iren", {31'd0, iREN}, 32'd0);
        apply('{32'h240, 1'b0, 32'h0});
        do_fill(32'h80, 0);
        tick();

        // Flush coinciding with the final accepted word.
        imemREN = 1'b1; imemaddr = 32'hC0;
        tick();
        exp_miss++;
        tick();
        flush = 1'b1;
        #1;
        chk("flw_iren", {31'd0, iREN}, 32'd1);
        chk("flw_iaddr", iaddr, 32'hC4);
        chk("flw_ihit", {31'd0, ihit}, 32'd0);
        tick();
        flush = 1'b0; imemREN = 1'b0;
        chk("flw_iren_after", {31'd0, iREN}, 32'd0);
        apply('{32'hC0, 1'b0, 32'h0});

        // Warm four lines, take real hit cycles, flush, all miss.
        do_fill(32'h000, 0); tick();
        do_fill(32'h008, 0); tick();
        do_fill(32'h010, 0); tick();
        do_fill(32'h018, 0); tick();
        foreach (warm[i]) apply(warm[i]);
        foreach (warm[i]) begin
            imemREN = 1'b1; imemaddr = warm[i].addr;
            tick();
            exp_hit++;
        end
        imemREN = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        foreach (warm[i]) apply('{warm[i].addr, 1'b0, 32'h0});
        apply('{32'h080, 1'b0, 32'h0});
`ifdef ICACHE_PERF_EN
        chk("perf_hit_cnt", hit_cnt, 32'(exp_hit));
        chk("perf_miss_cnt", miss_cnt, 32'(exp_miss));
`endif

        // Reset in the middle of a fill.
        do_fill(32'h008, 0);
        tick();
        imemREN = 1'b1; imemaddr = 32'h20;
        tick();
        iwait = 1'b1;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; imemREN = 1'b0; iwait = 1'b0;
        chk("rm_ihit", {31'd0, ihit}, 32'd0);
        chk("rm_iren", {31'd0, iREN}, 32'd0);
        chk("rm_iaddr", iaddr, 32'd0);
        apply('{32'h008, 1'b0, 32'h0});
        apply('{32'h020, 1'b0, 32'h0});
`ifdef ICACHE_PERF_EN
        chk("rm_hit_cnt", hit_cnt, 32'd0);
        chk("rm_miss_cnt", miss_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
